// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker
// Walks a combinational gate under test through every input vector, lets each
// vector settle for SETTLE cycles, samples the gate output once and compares
// it against the EXPECT truth table. Reports the mismatch count and pass/fail.
//
// Optional feature macro: FIRST_FAIL_CAPTURE_EN
//   When defined, adds o_fail_valid / o_fail_vec, which latch the input vector
//   of the first mismatch seen in a run.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | no run active; results of the last run held; waits for start
// S_WAIT   | current vector driven, settle counter running down to zero
// S_SAMPLE | compare resp to EXPECT[stim]; advance vector or finish run

module gate_truth_table_checker #(
   parameter int                   N_IN   = 2,
   parameter int                   SETTLE = 2,
   parameter logic [(1<<N_IN)-1:0] EXPECT = 4'b1000
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   output logic [N_IN-1:0] o_stim,
   input  logic            i_resp,
   output logic            o_busy,
   output logic            o_done,
   output logic            o_pass,
`ifdef FIRST_FAIL_CAPTURE_EN
   output logic            o_fail_valid,
   output logic [N_IN-1:0] o_fail_vec,
`endif
   output logic [N_IN:0]   o_err_count
);

   // Settle counter only needs to hold SETTLE-1.
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
   localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WAIT   = 2'd1,
      S_SAMPLE = 2'd2
   } state_t;

   state_t          r_state, w_state;
   logic [N_IN-1:0] r_stim, w_stim;
   logic [CW-1:0]   r_cnt, w_cnt;
   logic            r_busy, w_busy;
   logic            r_done, w_done;
   logic            r_pass, w_pass;
   logic [N_IN:0]   r_err, w_err;
   logic            w_mismatch;
`ifdef FIRST_FAIL_CAPTURE_EN
   logic            r_fail_valid, w_fail_valid;
   logic [N_IN-1:0] r_fail_vec, w_fail_vec;
`endif

   // Response check against the expected truth-table bit for the current vector.
   always_comb begin
      w_mismatch = (i_resp != EXPECT[r_stim]);
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state = r_state;
      w_stim  = r_stim;
      w_cnt   = r_cnt;
      w_busy  = r_busy;
      w_done  = 1'b0;
      w_pass  = r_pass;
      w_err   = r_err;
`ifdef FIRST_FAIL_CAPTURE_EN
      w_fail_valid = r_fail_valid;
      w_fail_vec   = r_fail_vec;
`endif
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_stim  = '0;
               w_err   = '0;
               w_pass  = 1'b0;
               w_busy  = 1'b1;
               w_cnt   = CNT_LOAD;
               w_state = S_WAIT;
`ifdef FIRST_FAIL_CAPTURE_EN
               w_fail_valid = 1'b0;
               w_fail_vec   = '0;
`endif
            end
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               w_state = S_SAMPLE;
            end else begin
               w_cnt = r_cnt - 1'b1;
            end
         end
         S_SAMPLE: begin
            if (w_mismatch) begin
               w_err = r_err + 1'b1;
`ifdef FIRST_FAIL_CAPTURE_EN
               if (!r_fail_valid) begin
                  w_fail_valid = 1'b1;
                  w_fail_vec   = r_stim;
               end
`endif
            end
            if (r_stim != LAST_VEC) begin
               w_stim  = r_stim + 1'b1;
               w_cnt   = CNT_LOAD;
               w_state = S_WAIT;
            end else begin
               // Final vector's own result must count toward pass.
               w_pass  = (r_err == '0) && !w_mismatch;
               w_done  = 1'b1;
               w_busy  = 1'b0;
               w_stim  = '0;
               w_state = S_IDLE;
            end
         end
         default: begin
            w_state = S_IDLE;
            w_busy  = 1'b0;
            w_stim  = '0;
         end
      endcase
   end

   // State and registered outputs; reset aborts any run without a done pulse.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_stim  <= '0;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_pass  <= 1'b0;
         r_err   <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
         r_fail_valid <= 1'b0;
         r_fail_vec   <= '0;
`endif
      end else begin
         r_state <= w_state;
         r_stim  <= w_stim;
         r_cnt   <= w_cnt;
         r_busy  <= w_busy;
         r_done  <= w_done;
         r_pass  <= w_pass;
         r_err   <= w_err;
`ifdef FIRST_FAIL_CAPTURE_EN
         r_fail_valid <= w_fail_valid;
         r_fail_vec   <= w_fail_vec;
`endif
      end
   end

   assign o_stim      = r_stim;
   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_pass      = r_pass;
   assign o_err_count = r_err;
`ifdef FIRST_FAIL_CAPTURE_EN
   assign o_fail_valid = r_fail_valid;
   assign o_fail_vec   = r_fail_vec;
`endif

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: two instances (2-input AND, SETTLE=2 and
// 3-input AND, SETTLE=1), each driven by a bench-side gate whose truth table
// is chosen per run. Expected results come from comparing whole truth tables.
module tb_gate_truth_table_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start_a = 1'b0;
   logic [1:0] stim_a;
   logic       resp_a;
   logic       busy_a, done_a, pass_a;
   logic [2:0] err_a;
   logic [3:0] tt_a = 4'b1000;

   logic       start_b = 1'b0;
   logic [2:0] stim_b;
   logic       resp_b;
   logic       busy_b, done_b, pass_b;
   logic [3:0] err_b;
   logic [7:0] tt_b = 8'h80;

`ifdef FIRST_FAIL_CAPTURE_EN
   logic       fv_a, fv_b;
   logic [1:0] fvec_a;
   logic [2:0] fvec_b;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [3:0] EXP_A = 4'b1000;
   localparam logic [7:0] EXP_B = 8'h80;

   always #5 clk = ~clk;

   // Gate under test models: plain truth-table lookup.
   assign resp_a = tt_a[stim_a];
   assign resp_b = tt_b[stim_b];

   gate_truth_table_checker #(.N_IN(2), .SETTLE(2), .EXPECT(4'b1000)) u_dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .o_stim(stim_a),
      .i_resp(resp_a), .o_busy(busy_a), .o_done(done_a), .o_pass(pass_a),
`ifdef FIRST_FAIL_CAPTURE_EN
      .o_fail_valid(fv_a), .o_fail_vec(fvec_a),
`endif
      .o_err_count(err_a)
   );

   gate_truth_table_checker #(.N_IN(3), .SETTLE(1), .EXPECT(8'h80)) u_dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .o_stim(stim_b),
      .i_resp(resp_b), .o_busy(busy_b), .o_done(done_b), .o_pass(pass_b),
`ifdef FIRST_FAIL_CAPTURE_EN
      .o_fail_valid(fv_b), .o_fail_vec(fvec_b),
`endif
      .o_err_count(err_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int first_bad(input logic [7:0] diff);
      for (int i = 0; i < 8; i++) if (diff[i]) return i;
      return 0;
   endfunction

   // Called just after the accepted start edge (edge 0); returns just after the last-sample edge.
   task automatic body_a();
      int exp_err;
      exp_err = $countones(tt_a ^ EXP_A);
      for (int e = 0; e < 12; e++) begin
         chk("a_stim", stim_a, e / 3);
         chk("a_busy", busy_a, 1);
         chk("a_done_low", done_a, 0);
         if (e == 0) chk("a_err_cleared", err_a, 0);
         tick();
      end
      chk("a_done", done_a, 1);
      chk("a_busy_end", busy_a, 0);
      chk("a_stim_end", stim_a, 0);
      chk("a_err", err_a, exp_err);
      chk("a_pass", pass_a, exp_err == 0);
`ifdef FIRST_FAIL_CAPTURE_EN
      chk("a_fail_valid", fv_a, exp_err != 0);
      chk("a_fail_vec", fvec_a, first_bad({4'b0, tt_a ^ EXP_A}));
`endif
   endtask

   task automatic run_a(input logic [3:0] tt);
      int exp_err;
      tt_a = tt;
      exp_err = $countones(tt ^ EXP_A);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      body_a();
      tick();
      chk("a_done_pulse", done_a, 0);
      chk("a_pass_held", pass_a, exp_err == 0);
      chk("a_err_held", err_a, exp_err);
   endtask

   task automatic run_b(input logic [7:0] tt);
      int exp_err;
      tt_b = tt;
      exp_err = $countones(tt ^ EXP_B);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int e = 0; e < 16; e++) begin
         chk("b_stim", stim_b, e / 2);
         chk("b_done_low", done_b, 0);
         tick();
      end
      chk("b_done", done_b, 1);
      chk("b_busy_end", busy_b, 0);
      chk("b_err", err_b, exp_err);
      chk("b_pass", pass_b, exp_err == 0);
`ifdef FIRST_FAIL_CAPTURE_EN
      chk("b_fail_valid", fv_b, exp_err != 0);
      chk("b_fail_vec", fvec_b, first_bad(tt ^ EXP_B));
`endif
      tick();
      chk("b_done_pulse", done_b, 0);
   endtask

   initial begin
      #2;
      chk("rst_stim_a", stim_a, 0);
      chk("rst_busy_a", busy_a, 0);
      chk("rst_done_a", done_a, 0);
      chk("rst_pass_a", pass_a, 0);
      chk("rst_err_a", err_a, 0);
      chk("rst_err_b", err_b, 0);
      rst_n = 1'b1;
      tick();
      tick();

      // Correct AND, stuck-at-0 output, OR gate in place of AND.
      run_a(4'b1000);
      run_a(4'b0000);
      run_a(4'b1110);

      // Reset in the middle of a run: everything clears at once, no done follows.
      tt_a = 4'b1000;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_busy", busy_a, 0);
      chk("midrst_stim", stim_a, 0);
      chk("midrst_done", done_a, 0);
      chk("midrst_pass", pass_a, 0);
      chk("midrst_err", err_a, 0);
      #2;
      rst_n = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         chk("midrst_no_done", done_a, 0);
      end
      run_a(4'b1000);

      // Back-to-back runs with start held high; first run has an error.
      tt_a = 4'b0000;
      start_a = 1'b1;
      tick();
      body_a();
      tt_a = 4'b1000;
      tick();
      chk("b2b_restart_busy", busy_a, 1);
      chk("b2b_restart_done", done_a, 0);
      body_a();
      start_a = 1'b0;
      tick();
      chk("b2b_idle_busy", busy_a, 0);
      chk("b2b_idle_done", done_a, 0);
      chk("b2b_pass_held", pass_a, 1);

      // 3-input AND.
      run_b(8'h80);
      run_b(8'h00);
      run_b(8'hFE);

      // Random gates: half the time the intended gate, otherwise a random table.
      for (int r = 0; r < 8; r++) begin
         if ($urandom_range(0, 1) == 0) run_a(EXP_A);
         else run_a(4'($urandom));
         if ($urandom_range(0, 1) == 0) run_b(EXP_B);
         else run_b(8'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
